ahblite_dma_master: RTL and testbench
=====================================

// Module: ahblite_dma_master
// PURPOSE
//  Single-channel word-copy engine acting as an AHB-Lite master (initiator) on the system bus.
//  Copies LEN 32-bit words from SRC to DST using non-overlapped NONSEQ single transfers.
//  Peripherals on the bus, e.g. the timer and GPIO slaves, are valid targets.
//  Sits beside the CPU; the bus matrix/arbiter grants it access. Control comes from sideband ports.
// PARAMETERS
//  LEN_W     16       width of the word-count input/counter (max copy = 2^LEN_W-1 words)
//  HPROT_VAL 4'b0011  constant HPROT driven on every transfer (privileged data access)
// PORTS
//  HCLK      in   1      bus clock
//  HRESETn   in   1      asynchronous, active-low reset
//  start     in   1      1-cycle request; sampled only in IDLE
//  src_addr  in   32     source byte address; bits[1:0] ignored (forced 0)
//  dst_addr  in   32     destination byte address; bits[1:0] ignored (forced 0)
//  len       in   LEN_W  number of words to copy
//  busy      out  1      high from the cycle after accepted start until DONE exits
//  done      out  1      1-cycle pulse at completion (normal, len==0 or error)
//  err       out  1      sticky error flag; cleared by next accepted start
//  HADDR     out  32     AHB address
//  HTRANS    out  2      AHB transfer type: IDLE 2'b00 or NONSEQ 2'b10 only
//  HWRITE    out  1      AHB direction
//  HSIZE     out  3      constant 3'b010 (word)
//  HBURST    out  3      constant 3'b000 (SINGLE)
//  HPROT     out  4      constant HPROT_VAL
//  HMASTLOCK out  1      constant 0
//  HWDATA    out  32     write data, valid in write data phase
//  HRDATA    in   32     read data
//  HREADY    in   1      bus ready; phase completes when high
//  HRESP     in   1      slave error response
// BEHAVIOUR
//  Reset: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, err=0, counters 0.
//  Reset mid-transfer aborts immediately: no completion pulse, partial copy left as is.
//  FSM (Moore; HTRANS/HADDR/HWRITE decoded from registered state/address only):
//   IDLE: start & len!=0 -> latch src/dst/len, clear err -> RD_A. start & len==0 -> DONE (no bus activity).
//   RD_A: HTRANS=NONSEQ, HADDR=src, HWRITE=0; hold until HREADY=1 -> RD_D.
//   RD_D: HTRANS=IDLE; on HREADY=1 capture HRDATA into buf -> WR_A.
//   WR_A: HTRANS=NONSEQ, HADDR=dst, HWRITE=1; hold until HREADY=1 -> WR_D.
//   WR_D: HTRANS=IDLE, HWDATA=buf (held stable for whole phase); on HREADY=1:
//         src+=4, dst+=4, remaining-=1; remaining was 1 -> DONE else -> RD_A.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  Throughput: 4 cycles/word at zero wait states; each wait state adds 1 cycle.
//  Address arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
//  Start while busy: ignored, no effect on the latched parameters.
//  Start in the DONE cycle: also ignored.
//  busy=1 in RD_A/RD_D/WR_A/WR_D and DONE after an accepted nonzero start; busy=0 in IDLE.
// CONFIGURATION
//  DMA_ERR_ABORT_EN defined: an HRESP=1 with HREADY=1 in RD_D or WR_D sets err=1 and goes to DONE.
//   - done still pulses; the failing word is not written or counted.
//   - HTRANS is already IDLE in data phases, so the 2-cycle error response is honoured.
//  Undefined: HRESP is ignored; the phase completes on HREADY and the copy continues; err stays 0.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE constants, dma_state_t enum.
//  No sub-module: FSM, address/length counters and data buffer live in this module.
// TESTING
//  1 zero-wait copy: src=0x100, dst=0x200, len=4 -> 4 reads then 4 writes interleaved, done at cycle 17, memory matches.
//  2 wait states: slave inserts 2 waits per phase, len=2 -> HADDR/HTRANS/HWDATA stable during waits, 24 bus cycles.
//  3 len=0 start -> no NONSEQ ever driven, done pulse 1 cycle after start, err=0.
//  4 start pulsed mid-copy with new src/dst -> ignored, original copy completes unchanged.
//  5 (DMA_ERR_ABORT_EN) error on 2nd read of len=3 -> err=1, done pulse, only word 0 written.
//  5 (without DMA_ERR_ABORT_EN) same stimulus -> all 3 words written, err=0.
//  6 HRESETn low during WR_A of word 1 -> HTRANS=IDLE asynchronously, busy=0, no done pulse.
//  6 new start after release -> correct full copy.
//  7 wrap: src=0xFFFF_FFF8, len=3 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the DMA copy-engine state type.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_DONE
    } dma_state_t;
endpackage

// File: rtl/ahblite_dma_master.sv
// ahblite_dma_master: single-channel AHB-Lite master copying LEN words SRC -> DST
// with non-overlapped NONSEQ single transfers (4 cycles/word at zero wait).
// Optional build macro DMA_ERR_ABORT_EN: an HRESP error in a data phase aborts the copy
// and sets the sticky err flag; otherwise HRESP is ignored.
module ahblite_dma_master
    import ahb_pkg::*;
#(
    parameter int unsigned LEN_W     = 16,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

`ifdef DMA_ERR_ABORT_EN
    localparam bit ERR_ABORT_EN = 1'b1;
`else
    localparam bit ERR_ABORT_EN = 1'b0;
`endif

    dma_state_t       state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] rem_q;
    logic             busy_q;
    logic             err_q;

    logic             addr_rd;
    logic             addr_wr;
    logic             resp_err;

    assign addr_rd  = (state_q == ST_RD_A);
    assign addr_wr  = (state_q == ST_WR_A);
    assign resp_err = ERR_ABORT_EN && HRESP;

    assign HTRANS    = (addr_rd || addr_wr) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = addr_wr ? dst_q : src_q;
    assign HWRITE    = addr_wr;
    assign HWDATA    = buf_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign busy      = busy_q;
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

    // Copy sequencer: one read then one write per word, each phase held until HREADY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    err_q <= 1'b0;
                    if (len != '0) begin
                        src_q   <= src_addr & ~32'd3;
                        dst_q   <= dst_addr & ~32'd3;
                        rem_q   <= len;
                        busy_q  <= 1'b1;
                        state_q <= ST_RD_A;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_RD_A: if (HREADY) state_q <= ST_RD_D;
                ST_RD_D: if (HREADY) begin
                    if (resp_err) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        buf_q   <= HRDATA;
                        state_q <= ST_WR_A;
                    end
                end
                ST_WR_A: if (HREADY) state_q <= ST_WR_D;
                ST_WR_D: if (HREADY) begin
                    if (resp_err) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        src_q   <= src_q + 32'd4;
                        dst_q   <= dst_q + 32'd4;
                        rem_q   <= rem_q - LEN_W'(1);
                        state_q <= (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_A;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahblite_dma_master.sv
// tb_ahblite_dma_master: directed bench with an AHB slave model and address/data scoreboards.
module tb_ahblite_dma_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int n_assert = 0;
    int n_fail = 0;
    int waits = 0;
    int wc = 0;
    int nonseq_cnt = 0;
    int done_cnt = 0;
    logic        err_on = 1'b0;
    logic [31:0] err_addr = '0;

    logic        dp_act = 1'b0;
    logic        dp_write = 1'b0;
    logic [31:0] dp_addr = '0;
    logic        a_hold = 1'b0;
    logic        w_hold = 1'b0;
    logic [31:0] a_sv = '0;
    logic [31:0] w_sv = '0;

    logic [31:0] rq[$];
    logic [31:0] wq[$];
    logic [31:0] dq[$];

    ahblite_dma_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave model: every phase (address or data) is stretched by `waits` low-HREADY cycles.
    assign HREADY = (wc == waits);
    assign HRDATA = (dp_act && !dp_write) ? pat(dp_addr) : 32'hDEAD_BEEF;
    assign HRESP  = err_on && dp_act && !dp_write && (dp_addr == err_addr);

    always @(posedge HCLK) begin
        if (!HRESETn || HREADY || !busy) wc <= 0;
        else wc <= wc + 1;
        if (!HRESETn) dp_act <= 1'b0;
        else if (HREADY) begin
            dp_act   <= (HTRANS == 2'b10);
            dp_addr  <= HADDR;
            dp_write <= HWRITE;
        end
    end

    // Monitor: scoreboard pops on completed phases and stability checks across wait states.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (a_hold) begin
                chk("addr_hold", HADDR, a_sv);
                chk("trans_hold", {30'd0, HTRANS}, 32'd2);
            end
            if (w_hold) chk("wdata_hold", HWDATA, w_sv);
            a_hold = (HTRANS == 2'b10) && !HREADY;
            a_sv   = HADDR;
            w_hold = dp_act && dp_write && !HREADY;
            w_sv   = HWDATA;
            if (HREADY && HTRANS == 2'b10) begin
                nonseq_cnt++;
                if (HWRITE) begin
                    n_assert++;
                    assert (wq.size() > 0) else begin
                        n_fail++;
                        $error("FAIL wr_unexp: got write to %h, expected none", HADDR);
                    end
                    if (wq.size() > 0) chk("wr_addr", HADDR, wq.pop_front());
                end else begin
                    n_assert++;
                    assert (rq.size() > 0) else begin
                        n_fail++;
                        $error("FAIL rd_unexp: got read of %h, expected none", HADDR);
                    end
                    if (rq.size() > 0) chk("rd_addr", HADDR, rq.pop_front());
                end
            end
            if (HREADY && dp_act && dp_write && dq.size() > 0) chk("wr_data", HWDATA, dq.pop_front());
            if (done) done_cnt++;
        end else begin
            a_hold = 1'b0;
            w_hold = 1'b0;
        end
    end

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        for (int i = 0; i < int'(n); i++) begin
            rq.push_back(s + 32'(4 * i));
            wq.push_back(d + 32'(4 * i));
            dq.push_back(pat(s + 32'(4 * i)));
        end
        @(negedge HCLK);
        src_addr = s;
        dst_addr = d;
        len = n;
        start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge HCLK);
            if (done) begin
                cyc = c;
                return;
            end
        end
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_rq"}, 32'(rq.size()), 32'd0);
        chk({tag, "_wq"}, 32'(wq.size()), 32'd0);
        chk({tag, "_dq"}, 32'(dq.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int nc0;
        int dc0;
        bit found;
        // Reset state
        repeat (3) @(negedge HCLK);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("const_sig", {20'd0, HSIZE, HBURST, HPROT, HMASTLOCK, 1'b0}, {20'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
        // 1: zero-wait copy
        start_copy(32'h100, 32'h200, 16'd4);
        wait_done(cyc);
        chk("t1_done_cycle", 32'(cyc), 32'd17);
        chk("t1_busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge HCLK);
        chk("t1_done_width", {31'd0, done}, 32'd0);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_err", {31'd0, err}, 32'd0);
        chk_drained("t1");
        // 2: two wait states per phase
        waits = 2;
        start_copy(32'h1000, 32'h2000, 16'd2);
        wait_done(cyc);
        chk("t2_done_cycle", 32'(cyc), 32'd25);
        @(negedge HCLK);
        chk_drained("t2");
        waits = 0;
        // 3: len == 0
        nc0 = nonseq_cnt;
        start_copy(32'h100, 32'h200, 16'd0);
        wait_done(cyc);
        chk("t3_done_cycle", 32'(cyc), 32'd1);
        chk("t3_err", {31'd0, err}, 32'd0);
        @(negedge HCLK);
        chk("t3_no_bus", 32'(nonseq_cnt), 32'(nc0));
        chk("t3_done_width", {31'd0, done}, 32'd0);
        // 4: start while busy and in DONE are ignored
        start_copy(32'h300, 32'h400, 16'd3);
        repeat (5) @(negedge HCLK);
        src_addr = 32'h900;
        dst_addr = 32'hA00;
        len = 16'd5;
        start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        wait_done(cyc);
        chk("t4_done_seen", {31'd0, cyc > 0}, 32'd1);
        nc0 = nonseq_cnt;
        start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        @(negedge HCLK);
        chk("t4_start_in_done_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge HCLK);
        chk("t4_start_in_done_bus", 32'(nonseq_cnt), 32'(nc0));
        chk_drained("t4");
        // 5: error response on the second read
        waits = 1;
        err_on = 1'b1;
        err_addr = 32'h504;
        start_copy(32'h500, 32'h600, 16'd3);
`ifdef DMA_ERR_ABORT_EN
        rq.delete(2);
        wq.delete(2);
        wq.delete(1);
        dq.delete(2);
        dq.delete(1);
`endif
        wait_done(cyc);
        chk("t5_done_seen", {31'd0, cyc > 0}, 32'd1);
`ifdef DMA_ERR_ABORT_EN
        chk("t5_err", {31'd0, err}, 32'd1);
`else
        chk("t5_err", {31'd0, err}, 32'd0);
`endif
        @(negedge HCLK);
        chk_drained("t5");
        err_on = 1'b0;
        waits = 0;
        // 6: reset during WR_A of word 1, then a clean copy
        dc0 = done_cnt;
        start_copy(32'h700, 32'h800, 16'd4);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge HCLK);
            found = (HTRANS == 2'b10) && HWRITE && (HADDR == 32'h804);
        end
        chk("t6_reached_wr1", {31'd0, found}, 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_haddr", HADDR, 32'd0);
        repeat (3) @(negedge HCLK);
        chk("t6_no_done", 32'(done_cnt), 32'(dc0));
        rq.delete();
        wq.delete();
        dq.delete();
        HRESETn = 1'b1;
        start_copy(32'h700, 32'h800, 16'd4);
        wait_done(cyc);
        chk("t6_done_cycle", 32'(cyc), 32'd17);
        chk("t6_err", {31'd0, err}, 32'd0);
        @(negedge HCLK);
        chk_drained("t6");
        // 7: source address wraps past 0xFFFF_FFFC
        start_copy(32'hFFFF_FFF8, 32'h3000, 16'd3);
        wait_done(cyc);
        chk("t7_done_cycle", 32'(cyc), 32'd13);
        @(negedge HCLK);
        chk_drained("t7");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
